// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, issues req/ack instruction reads and hands the word to the decoder.
// Optional accepted-instruction counter enabled by defining IFU_INSTR_COUNT_EN.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset_n,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [31:0] IMemData,
   output logic [31:0] Instr,
   output logic [5:0]  Op,
   output logic [31:0] PCPlus4,
   output logic        InstrValid,
   input  logic        InstrReady,
   input  logic        Branch,
   input  logic        Jump,
   input  logic        Zero,
   output logic [31:0] InstrCount
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t            state, state_d;
   logic [XLEN-1:0]   pc, pc_d;
   logic              req_d, valid_d;
   logic [XLEN-1:0]   addr_d, instr_d, pc4_d;
   logic [XLEN-1:0]   next_pc, jump_target, branch_off;

   assign Op = Instr[31:26];

   // Control-flow target of the held instruction, Jump taking priority over a taken branch.
   always_comb begin
      jump_target = {PCPlus4[31:28], Instr[25:0], 2'b00};
      branch_off  = {{14{Instr[15]}}, Instr[15:0], 2'b00};
      next_pc     = PCPlus4;
      if (Jump) begin
         next_pc = jump_target;
      end else if (Branch && Zero) begin
         next_pc = PCPlus4 + branch_off;
      end
   end

   always_comb begin
      state_d = state;
      pc_d    = pc;
      req_d   = IMemReq;
      addr_d  = IMemAddr;
      instr_d = Instr;
      pc4_d   = PCPlus4;
      valid_d = InstrValid;
      case (state)
         IDLE: begin
            req_d   = 1'b1;
            addr_d  = pc;
            state_d = FETCH;
         end
         FETCH: begin
            if (IMemAck) begin
               instr_d = IMemData;
               pc4_d   = pc + 32'd4;
               valid_d = 1'b1;
               req_d   = 1'b0;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (InstrReady) begin
               pc_d    = next_pc;
               addr_d  = next_pc;
               valid_d = 1'b0;
               req_d   = 1'b1;
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         IMemReq    <= 1'b0;
         IMemAddr   <= RESET_PC;
         Instr      <= '0;
         PCPlus4    <= RESET_PC + 32'd4;
         InstrValid <= 1'b0;
      end else begin
         state      <= state_d;
         pc         <= pc_d;
         IMemReq    <= req_d;
         IMemAddr   <= addr_d;
         Instr      <= instr_d;
         PCPlus4    <= pc4_d;
         InstrValid <= valid_d;
      end
   end

`ifdef IFU_INSTR_COUNT_EN
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         InstrCount <= '0;
      end else if (InstrValid && InstrReady) begin
         InstrCount <= InstrCount + 32'd1;
      end
   end
`else
   assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: three instances with different reset PCs share one
// directed stimulus; a transaction-level model is compared every cycle, plus literal checks.
module tb_instruction_fetch_unit;

   localparam logic [2:0][31:0] RPS = {32'hFFFF_FFFC, 32'h1000_0008, 32'h0000_0000};
`ifdef IFU_INSTR_COUNT_EN
   localparam logic [31:0] CNT_INC = 32'd1;
`else
   localparam logic [31:0] CNT_INC = 32'd0;
`endif

   localparam logic [31:0] I_LW  = 32'h8C01_0004;
   localparam logic [31:0] I_J1  = 32'h0800_0040;
   localparam logic [31:0] I_J2  = 32'h0800_0004;
   localparam logic [31:0] I_BEQ = 32'h1022_0003;

   logic        Clk, Reset_n;
   logic        IMemAck, InstrReady, Branch, Jump, Zero;
   logic [31:0] IMemData;

   logic        o_req   [3];
   logic [31:0] o_addr  [3];
   logic [31:0] o_instr [3];
   logic [5:0]  o_op    [3];
   logic [31:0] o_pc4   [3];
   logic        o_valid [3];
   logic [31:0] o_cnt   [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      instruction_fetch_unit #(.RESET_PC(RPS[g])) u_dut (
         .Clk        (Clk),
         .Reset_n    (Reset_n),
         .IMemReq    (o_req[g]),
         .IMemAddr   (o_addr[g]),
         .IMemAck    (IMemAck),
         .IMemData   (IMemData),
         .Instr      (o_instr[g]),
         .Op         (o_op[g]),
         .PCPlus4    (o_pc4[g]),
         .InstrValid (o_valid[g]),
         .InstrReady (InstrReady),
         .Branch     (Branch),
         .Jump       (Jump),
         .Zero       (Zero),
         .InstrCount (o_cnt[g])
      );
   end

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Transaction-level model: what each instance must show after every clock.
   logic [31:0] m_pc [3], m_addr [3], m_instr [3], m_pc4 [3], m_cnt [3];
   logic        m_req [3], m_valid [3], m_idle [3];

   function automatic logic [31:0] target(input logic [31:0] pc4, input logic [31:0] ins,
                                          input logic br, input logic jmp, input logic z);
      int off;
      off = $signed(ins[15:0]);
      if (jmp) return {pc4[31:28], ins[25:0], 2'b00};
      if (br && z) return pc4 + 32'(off * 4);
      return pc4;
   endfunction

   always @(posedge Clk or negedge Reset_n) begin
      for (int k = 0; k < 3; k++) begin
         if (!Reset_n) begin
            m_pc[k]    <= RPS[k];
            m_addr[k]  <= RPS[k];
            m_instr[k] <= '0;
            m_pc4[k]   <= RPS[k] + 32'd4;
            m_cnt[k]   <= '0;
            m_req[k]   <= 1'b0;
            m_valid[k] <= 1'b0;
            m_idle[k]  <= 1'b1;
         end else if (m_idle[k]) begin
            m_idle[k] <= 1'b0;
            m_req[k]  <= 1'b1;
            m_addr[k] <= m_pc[k];
         end else if (m_req[k] && IMemAck) begin
            m_instr[k] <= IMemData;
            m_pc4[k]   <= m_pc[k] + 32'd4;
            m_valid[k] <= 1'b1;
            m_req[k]   <= 1'b0;
         end else if (m_valid[k] && InstrReady) begin
            m_pc[k]    <= target(m_pc4[k], m_instr[k], Branch, Jump, Zero);
            m_addr[k]  <= target(m_pc4[k], m_instr[k], Branch, Jump, Zero);
            m_valid[k] <= 1'b0;
            m_req[k]   <= 1'b1;
            m_cnt[k]   <= m_cnt[k] + CNT_INC;
         end
      end
   end

   int          vectors = 0;
   int          errors  = 0;
   int          chk_sel = 0;
   logic [31:0] chk_exp = '0;
   logic [31:0] act;

   // Single compare process: model check every cycle plus one optional literal check.
   always @(negedge Clk) begin
      for (int k = 0; k < 3; k++) begin
         vectors = vectors + 1;
         if (o_req[k] !== m_req[k] || o_addr[k] !== m_addr[k] || o_instr[k] !== m_instr[k] ||
             o_op[k] !== m_instr[k][31:26] || o_pc4[k] !== m_pc4[k] ||
             o_valid[k] !== m_valid[k] || o_cnt[k] !== m_cnt[k]) begin
            errors = errors + 1;
            $display("FAIL model[%0d] t=%0t got req=%b addr=%h instr=%h op=%h pc4=%h v=%b cnt=%h want req=%b addr=%h instr=%h op=%h pc4=%h v=%b cnt=%h",
                     k, $time, o_req[k], o_addr[k], o_instr[k], o_op[k], o_pc4[k], o_valid[k], o_cnt[k],
                     m_req[k], m_addr[k], m_instr[k], m_instr[k][31:26], m_pc4[k], m_valid[k], m_cnt[k]);
         end
      end
      if (chk_sel != 0) begin
         case (chk_sel)
            1:       act = o_addr[0];
            2:       act = 32'(o_op[0]);
            3:       act = 32'(o_valid[0]);
            4:       act = 32'(o_req[0]);
            5:       act = o_addr[1];
            6:       act = o_addr[2];
            7:       act = o_cnt[2];
            default: act = o_instr[0];
         endcase
         vectors = vectors + 1;
         if (act !== chk_exp) begin
            errors = errors + 1;
            $display("FAIL literal sel=%0d t=%0t got %h want %h", chk_sel, $time, act, chk_exp);
         end
      end
   end

   task automatic st(input logic a, input logic [31:0] d, input logic r, input logic b,
                     input logic j, input logic z, input int sel, input logic [31:0] exp);
      IMemAck    = a;
      IMemData   = d;
      InstrReady = r;
      Branch     = b;
      Jump       = j;
      Zero       = z;
      chk_sel    = sel;
      chk_exp    = exp;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset_n = 1'b0;
      IMemAck = 1'b0; IMemData = '0; InstrReady = 1'b0;
      Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
      @(posedge Clk);
      #1;
      repeat (2) st(0, 0, 0, 0, 0, 0, 4, 0);
      Reset_n = 1'b1;

      // lw at reset PC, sequential accept; reset PC 0xFFFF_FFFC wraps to 0
      st(0, 0,    0, 0, 0, 0, 3, 0);
      st(1, I_LW, 0, 0, 0, 0, 1, 32'h0);
      st(0, 0,    1, 0, 0, 0, 2, 32'h23);
      st(0, 0,    0, 0, 0, 0, 1, 32'h4);
      st(0, 0,    0, 0, 0, 0, 6, 32'h0);
      st(0, 0,    0, 0, 0, 0, 7, CNT_INC);

      // j with Branch also set: jump wins
      Reset_n = 1'b0;
      st(0, 0,    0, 0, 0, 0, 4, 0);
      Reset_n = 1'b1;
      st(0, 0,    0, 0, 0, 0, 5, 32'h1000_0008);
      st(1, I_J1, 0, 0, 0, 0, 0, 0);
      st(0, 0,    1, 1, 1, 1, 0, 0);
      st(0, 0,    0, 0, 0, 0, 5, 32'h1000_0100);

      // beq at 0x10 taken, then not taken
      st(1, I_J2,  0, 0, 0, 0, 1, 32'h100);
      st(0, 0,     1, 0, 1, 0, 0, 0);
      st(1, I_BEQ, 0, 0, 0, 0, 1, 32'h10);
      st(0, 0,     1, 1, 0, 1, 0, 0);
      st(1, I_J2,  0, 0, 0, 0, 1, 32'h20);
      st(0, 0,     1, 0, 1, 0, 0, 0);
      st(1, I_BEQ, 0, 0, 0, 0, 1, 32'h10);
      st(0, 0,     1, 1, 0, 0, 0, 0);

      // delayed ack, then stalled consumer with stray acks during hold
      st(0, 0, 0, 0, 0, 0, 1, 32'h14);
      repeat (4) st(0, 0, 0, 0, 0, 0, 4, 32'h1);
      st(1, 32'h2002_0005, 0, 0, 0, 0, 1, 32'h14);
      st(1, 32'h1234_5678, 0, 0, 0, 0, 8, 32'h2002_0005);
      st(0, 0,             0, 0, 0, 0, 3, 32'h1);
      st(1, 32'h1234_5678, 0, 0, 0, 0, 8, 32'h2002_0005);
      st(0, 0,             0, 0, 0, 0, 4, 32'h0);
      st(0, 0,             1, 0, 0, 0, 0, 0);
      st(0, 0,             0, 0, 0, 0, 1, 32'h18);

      // reset mid-fetch, stray ack during reset and in IDLE
      Reset_n = 1'b0;
      st(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 4, 32'h0);
      Reset_n = 1'b1;
      st(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 3, 32'h0);
      st(0, 0,             0, 0, 0, 0, 1, 32'h0);
      st(0, 0,             0, 0, 0, 0, 3, 32'h0);
      st(0, 0,             0, 0, 0, 0, 0, 0);

      @(negedge Clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
